// File: rtl/vending_machine_gen.sv
// Parametrised vending controller: per-channel price and stock tables, credit with
// overflow rejection, quarter-by-quarter change return and optional auto change.
module vending_machine_gen #(
    parameter int unsigned                  NUM_PROD    = 4,
    parameter int unsigned                  CREDIT_W    = 12,
    parameter int unsigned                  CREDIT_MAX  = 1000,
    parameter int unsigned                  STOCK_W     = 4,
    parameter int unsigned                  STOCK_INIT  = 10,
    parameter int unsigned                  STOCK_MAX   = 15,
    parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES      = {12'd200, 12'd150, 12'd75, 12'd25},
    parameter bit                           AUTO_CHANGE = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_q,
    input  logic                coin_d,
    input  logic [NUM_PROD-1:0] select,
    input  logic                buy,
    input  logic                refund,
    input  logic [NUM_PROD-1:0] load,
    output logic [CREDIT_W-1:0] credit,
    output logic [NUM_PROD-1:0] dispense,
    output logic                change_q,
    output logic [NUM_PROD-1:0] out_of_stock,
    output logic                busy,
    output logic                coin_reject,
    output logic                vend_fail
);
    typedef enum logic [1:0] {StIdle, StVend, StChange} state_e;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [STOCK_W-1:0]  stock_q [NUM_PROD];
    logic [STOCK_W-1:0]  stock_d [NUM_PROD];
    logic [NUM_PROD-1:0] dispense_q, dispense_d, oos_q;
    logic                chg_q, chg_d, busy_q, reject_q, reject_d, fail_q, fail_d;
    logic                coin_q_h, coin_d_h, buy_h, refund_h;
    logic                coin_q_e, coin_d_e, buy_e, refund_e, coin_e;
    logic [CREDIT_W-1:0] price_sel;
    logic                stock_ok, vend_ok;
    logic [31:0]         run;

    assign coin_q_e = coin_q & ~coin_q_h;
    assign coin_d_e = coin_d & ~coin_d_h;
    assign buy_e    = buy & ~buy_h;
    assign refund_e = refund & ~refund_h;
    assign coin_e   = coin_q_e | coin_d_e;

    always_comb begin
        price_sel = '0;
        stock_ok  = 1'b0;
        for (int unsigned i = 0; i < NUM_PROD; i++) begin
            if (select[i]) begin
                price_sel = PRICES[i*CREDIT_W +: CREDIT_W];
                stock_ok  = (stock_q[i] != '0);
            end
        end
        vend_ok = buy_e && $onehot(select) && stock_ok && (credit_q >= price_sel);
    end

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        stock_d    = stock_q;
        dispense_d = '0;
        chg_d      = 1'b0;
        reject_d   = 1'b0;
        fail_d     = 1'b0;
        run        = '0;
        unique case (state_q)
            StIdle: begin
                if (refund_e) begin
                    state_d  = StChange;
                    reject_d = coin_e;
                end else begin
                    if (vend_ok) begin
                        credit_d   = credit_q - price_sel;
                        dispense_d = select;
                        state_d    = StVend;
                        for (int unsigned i = 0; i < NUM_PROD; i++) begin
                            if (select[i]) stock_d[i] = stock_q[i] - STOCK_W'(1);
                        end
                    end else if (buy_e) begin
                        fail_d = 1'b1;
                    end
                    // Coins are judged against the credit left after a same-cycle vend.
                    run = 32'(credit_d);
                    if (coin_d_e) begin
                        if (run + 32'd100 <= CREDIT_MAX) run = run + 32'd100;
                        else reject_d = 1'b1;
                    end
                    if (coin_q_e) begin
                        if (run + 32'd25 <= CREDIT_MAX) run = run + 32'd25;
                        else reject_d = 1'b1;
                    end
                    credit_d = CREDIT_W'(run);
                end
            end
            StVend: begin
                reject_d = coin_e;
                state_d  = (AUTO_CHANGE && credit_q != '0) ? StChange : StIdle;
            end
            StChange: begin
                reject_d = coin_e;
                if (credit_q == '0) begin
                    state_d = StIdle;
                end else if (!chg_q) begin
                    chg_d    = 1'b1;
                    credit_d = credit_q - CREDIT_W'(25);
                end
            end
            default: state_d = StIdle;
        endcase
        // Restock is applied last so it overrides a same-cycle vend decrement.
        for (int unsigned i = 0; i < NUM_PROD; i++) begin
            if (load[i]) stock_d[i] = STOCK_W'(STOCK_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            credit_q   <= '0;
            dispense_q <= '0;
            chg_q      <= 1'b0;
            oos_q      <= '0;
            busy_q     <= 1'b0;
            reject_q   <= 1'b0;
            fail_q     <= 1'b0;
            coin_q_h   <= 1'b1;
            coin_d_h   <= 1'b1;
            buy_h      <= 1'b1;
            refund_h   <= 1'b1;
            for (int unsigned i = 0; i < NUM_PROD; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            dispense_q <= dispense_d;
            chg_q      <= chg_d;
            busy_q     <= (state_d != StIdle);
            reject_q   <= reject_d;
            fail_q     <= fail_d;
            coin_q_h   <= coin_q;
            coin_d_h   <= coin_d;
            buy_h      <= buy;
            refund_h   <= refund;
            stock_q    <= stock_d;
            for (int unsigned i = 0; i < NUM_PROD; i++) oos_q[i] <= (stock_q[i] == '0);
        end
    end

    assign credit       = credit_q;
    assign dispense     = dispense_q;
    assign change_q     = chg_q;
    assign out_of_stock = oos_q;
    assign busy         = busy_q;
    assign coin_reject  = reject_q;
    assign vend_fail    = fail_q;
endmodule

// File: doc/vending_machine_gen.md
Name: vending_machine_gen

Overview:
- Parametrised next-generation vending controller: NUM_PROD product channels, per-channel price table, configurable credit and stock widths.
- Adds refund with quarter-by-quarter change return, optional automatic change after a vend, coin rejection on credit overflow, vend-failure reporting and multi-channel restock.
- Sits between the coin/button front end and the dispenser/change-hopper drivers. All inputs are already synchronous to clk.

Parameters:
- NUM_PROD, 4: number of product channels.
- CREDIT_W, 12: credit register width in cents.
- CREDIT_MAX, 1000: maximum credit held, in cents; must be a multiple of 25 and less than 2^CREDIT_W.
- STOCK_W, 4: per-channel stock counter width.
- STOCK_INIT, 10: stock of every channel after reset.
- STOCK_MAX, 15: stock value written on load; must be at most 2^STOCK_W-1.
- PRICES, {12'd200,12'd150,12'd75,12'd25}: packed NUM_PROD*CREDIT_W vector; channel i price is slice i, so channel 0 = 25. Every price is a multiple of 25 and nonzero.
- AUTO_CHANGE, 0: 1 = return remaining credit automatically after every successful vend.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- coin_q  in  1  quarter inserted (25 cents), level; rising edge counts.
- coin_d  in  1  dollar inserted (100 cents), level; rising edge counts.
- select  in  NUM_PROD  one-hot product select, sampled on the buy edge.
- buy  in  1  purchase request, level; rising edge counts.
- refund  in  1  change request, level; rising edge counts.
- load  in  NUM_PROD  restock request per channel, level, multi-hot allowed.
- credit  out  CREDIT_W  current credit in cents.
- dispense  out  NUM_PROD  one-cycle pulse on the vended channel.
- change_q  out  1  one-cycle pulse per quarter returned.
- out_of_stock  out  NUM_PROD  registered flag, stock==0 per channel.
- busy  out  1  high in the VEND and CHANGE states.
- coin_reject  out  1  one-cycle pulse when a coin edge is refused.
- vend_fail  out  1  one-cycle pulse when a buy edge is refused.

Behaviour:
- Reset (async assert, sync release):
  - credit=0, dispense=0, change_q=0, out_of_stock=0, busy=0, coin_reject=0, vend_fail=0.
  - Every stock counter = STOCK_INIT; state = IDLE.
  - Edge-detect history registers reset to 1, so inputs already high at reset release do not count as edges.
- Edge detection: edge = input high this cycle and history register low. All actions take effect at that same clock edge; outputs are registered, so responses appear one cycle after the input is sampled high.
- State IDLE, priority within one cycle:
  1. refund edge: go to CHANGE. A simultaneous buy edge is ignored with no vend_fail. Simultaneous coin edges are rejected.
  2. buy edge: a vend succeeds only if select is exactly one-hot, that channel's stock is greater than 0, and credit is at least that channel's price.
     - Success: credit -= price, stock -= 1, go to VEND.
     - Failure: vend_fail pulse, stay in IDLE.
  3. Coin edges, evaluated against the credit after any vend in the same cycle:
     - coin_d first: +100 if the result is at most CREDIT_MAX.
     - then coin_q: +25 if the running result is at most CREDIT_MAX.
     - Each refused coin makes coin_reject pulse (one pulse even if both coins are refused).
- State VEND (exactly 1 cycle):
  - dispense[i] high for this cycle only.
  - Next state is CHANGE if AUTO_CHANGE=1 and credit>0, else IDLE.
- State CHANGE:
  - If credit==0, return to IDLE on the next cycle with no pulse.
  - Otherwise alternate change_q high for one cycle and low for one cycle. credit decrements by 25 on each high cycle.
  - Return to IDLE in the cycle after the pulse that brings credit to 0.
- Busy states (VEND, CHANGE): coin edges are rejected (coin_reject pulse). buy and refund edges are ignored silently. History registers keep updating in every state.
- Load: accepted in every state. Each set bit writes stock=STOCK_MAX. If a load and a vend hit the same channel in the same cycle, load wins (result STOCK_MAX).
- out_of_stock[i] is registered (stock_i==0) and lags the stock counter by one cycle.
- Arithmetic: credit never exceeds CREDIT_MAX and never underflows. Stock never underflows, because the vend is blocked at 0. No wrap-around is possible.
- Reset asserted mid-VEND or mid-CHANGE: immediate return to reset values. Credit not yet returned is lost.

Test Plan:
- Reset with coin_q held high, then release; pulse coin_d once -> credit=100 and no 25 is added from the held coin_q; out_of_stock=0000.
- Insert 4 dollars (credit 400), select=0100, buy -> dispense=0100 for 1 cycle, credit=250, busy high 1 cycle. Then refund -> 10 change_q pulses on alternate cycles, credit=0, IDLE.
- With credit=50: buy with select=0010 (price 75) -> vend_fail, credit stays 50. buy with select=0011 -> vend_fail.
- Credit=950: coin_d and coin_q edges in the same cycle -> coin_d rejected, coin_q accepted, credit=975, coin_reject pulses once.
- Ten buys on channel 0 from credit 250 -> stock0=0 and out_of_stock[0]=1 one cycle later. An 11th buy -> vend_fail. load=0001 -> out_of_stock[0] clears, stock=15.
- With AUTO_CHANGE=1 and credit=100, buy channel 1 -> dispense[1], then exactly one change_q pulse, credit=0. Assert rst_n low during CHANGE -> all outputs reset asynchronously.
